can_tx_framer: RTL and testbench
================================

CAN_TX_FRAMER -- requirements
Module: can_tx_framer

Interface
REQ-001 Parameter STUFF_LEN, default 5: number of consecutive identical bits that forces a stuff bit.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bit_tick  input  1  one-cycle strobe marking each CAN bit time; may stay high continuously.
REQ-005 start  input  1  frame request, sampled only while busy=0.
REQ-006 id  input  11  base identifier, sent MSB first.
REQ-007 dlc  input  4  data length code, sent as given.
REQ-008 data  input  64  payload; byte 0 = data[63:56], each byte sent MSB first.
REQ-009 tx  output  1  serial CAN bit; 1 = recessive.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse at frame completion.

Function
REQ-012 Frame type: base-format data frame only. Field order: SOF(0), ID[10:0], RTR(0), IDE(0), r0(0), DLC[3:0], data, CRC[14:0], CRC delimiter(1), ACK slot(1), ACK delimiter(1), EOF(7×1), IFS(3×1).
REQ-013 Data byte count = min(dlc, 8); dlc 9..15 sends 8 bytes.
REQ-014 start with busy=0 latches id/dlc/data; busy=1 next cycle; start while busy=1 is ignored and latched fields do not change.
REQ-015 tx is registered, updating only in the cycle after a bit_tick; without bit_tick it holds.
REQ-016 First bit_tick after acceptance drives SOF; each later bit_tick drives exactly one bit (frame or stuff).
REQ-017 States: IDLE, ARB (ID+RTR), CTRL (IDE, r0, DLC), DATA, CRC, CRC_DEL, ACK, EOF (ACK delimiter + 7 EOF bits), IFS; DATA is skipped when the byte count is 0.
REQ-018 Stuffing covers SOF through the last CRC bit: after STUFF_LEN identical consecutive bits, the next bit_tick sends their complement and the field does not advance.
REQ-019 A stuff bit starts a new run of length 1; a stuff bit is still inserted after CRC[0] if CRC[0] completes a run, before CRC_DEL.
REQ-020 No stuffing from CRC_DEL onward.
REQ-021 CRC-15: polynomial 0x4599, cleared to 0 at start acceptance, computed over non-stuff bits SOF through last data bit; stuff bits are excluded.
REQ-022 CRC field sends the CRC value registered after the last data bit (or after DLC[0] when byte count is 0).
REQ-023 done pulses in the cycle after the bit_tick that ends the third IFS bit, and busy=0 in that same cycle.
REQ-024 start may be accepted in the same cycle that done is high.
REQ-025 Idle outputs: tx=1, busy=0, done=0.

Reset
REQ-026 rst at any time, including mid-frame, SHALL force the following on the next edge: IDLE, tx=1, busy=0, done=0, stuff run count=0, CRC register=0, and latched fields cleared.
REQ-027 After reset, no partial frame resumes; the next frame needs a new start.

Structure
REQ-028 A shared package SHALL hold: state enum, CRC polynomial 15'h4599, field widths (ID 11, DLC 4, CRC 15), EOF length 7, IFS length 3, max data bytes 8.
REQ-029 The CRC SHALL be a can_crc sub-module instance (clk, rst, data_in, enable, crc_reg[14:0]).
REQ-030 Its rst input SHALL be driven by rst OR start-acceptance; its enable input SHALL be bit_tick AND a non-stuff bit in SOF..data.
REQ-031 The framer SHALL hold one bit counter, one run counter and one run-value register; no other sub-modules.

Verification
REQ-032 id=0x000, dlc=0, continuous bit_tick -> 34 zero frame bits with CRC=0, 6 stuff 1s, done after exactly 53 bit_ticks.
REQ-033 id=0x7FF, dlc=0 -> first 14 tx bits 0,1,1,1,1,1,0,1,1,1,1,1,0,1.
REQ-034 dlc=9, data=0x0123456789ABCDEF -> DLC field 1001; 8 bytes; 98 unstuffed bits before CRC_DEL; CRC and stuffing match the bench bit-accurate model.
REQ-035 start pulsed again mid-ARB with different id -> transmitted frame unchanged; second start ignored.
REQ-036 rst asserted during DATA -> next cycle tx=1, busy=0, done=0; new start -> clean SOF and correct CRC.
REQ-037 bit_tick every 7 cycles -> tx changes only the cycle after each tick; bit sequence identical to the continuous-tick case.

Source files
------------

// File: rtl/can_tx_framer_pkg.sv
// Shared constants and types for the CAN base-frame transmitter.
// Field widths, frame tail lengths and the CRC-15 polynomial live here.
package can_tx_framer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_EOF,
        ST_IFS
    } state_t;

    localparam logic [14:0] CRC_POLY  = 15'h4599;
    localparam int          ID_W      = 11;
    localparam int          DLC_W     = 4;
    localparam int          CRC_W     = 15;
    localparam int          EOF_LEN   = 7;
    localparam int          IFS_LEN   = 3;
    localparam int          MAX_BYTES = 8;

    // dlc values above 8 still carry eight payload bytes
    function automatic logic [3:0] byte_count(input logic [3:0] dlc);
        return (dlc > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc;
    endfunction

endpackage

// File: rtl/can_tx_framer_crc.sv
// CRC-15 shift register for CAN; one bit folded in per enabled cycle.
// Cleared synchronously whenever rst is high.
module can_crc
    import can_tx_framer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             enable,
    output logic [CRC_W-1:0] crc_reg
);

    logic feedback;
    assign feedback = data_in ^ crc_reg[CRC_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg <= '0;
        end else if (enable) begin
            crc_reg <= {crc_reg[CRC_W-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/can_tx_framer.sv
// Serialises one base-format CAN data frame per accepted start, with bit
// stuffing from SOF through the CRC field and a registered tx line.
module can_tx_framer
    import can_tx_framer_pkg::*;
#(
    parameter int STUFF_LEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick,
    input  logic        start,
    input  logic [10:0] id,
    input  logic [3:0]  dlc,
    input  logic [63:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);

    state_t             state, state_n;
    logic [6:0]         bit_cnt, bit_cnt_n;
    logic [RUN_W-1:0]   run_cnt, run_cnt_n;
    logic               run_val, run_val_n;
    logic               tx_q, tx_n;
    logic               done_q, done_n;
    logic [10:0]        id_q, id_n;
    logic [3:0]         dlc_q, dlc_n;
    logic [63:0]        data_q, data_n;

    logic               accept;
    logic               frame_bit;
    logic               last_bit;
    logic               stuff_zone;
    logic               stuff_now;
    logic               crc_en;
    logic               crc_rst;
    logic [3:0]         n_bytes;
    logic [CRC_W-1:0]   crc_val;
    state_t             next_field;

    assign accept  = (state == ST_IDLE) && start;
    assign crc_rst = rst || accept;
    assign n_bytes = byte_count(dlc_q);
    assign tx      = tx_q;
    assign done    = done_q;
    assign busy    = (state != ST_IDLE);

    can_crc u_crc (
        .clk     (clk),
        .rst     (crc_rst),
        .data_in (frame_bit),
        .enable  (crc_en),
        .crc_reg (crc_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            run_cnt <= '0;
            run_val <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            id_q    <= '0;
            dlc_q   <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            run_cnt <= run_cnt_n;
            run_val <= run_val_n;
            tx_q    <= tx_n;
            done_q  <= done_n;
            id_q    <= id_n;
            dlc_q   <= dlc_n;
            data_q  <= data_n;
        end
    end

    // Bit value and end-of-field decode for the current state and counter
    always_comb begin
        frame_bit  = 1'b1;
        last_bit   = 1'b0;
        next_field = state;
        case (state)
            ST_ARB: begin
                // count 0 is SOF, 1..11 the identifier, 12 is RTR
                if (bit_cnt >= 7'd1 && bit_cnt <= 7'(ID_W))
                    frame_bit = id_q[4'(4'd11 - bit_cnt[3:0])];
                else
                    frame_bit = 1'b0;
                last_bit   = (bit_cnt == 7'(ID_W + 1));
                next_field = ST_CTRL;
            end
            ST_CTRL: begin
                if (bit_cnt >= 7'd2)
                    frame_bit = dlc_q[2'(3'd5 - bit_cnt[2:0])];
                else
                    frame_bit = 1'b0;
                last_bit   = (bit_cnt == 7'(DLC_W + 1));
                next_field = (n_bytes == 4'd0) ? ST_CRC : ST_DATA;
            end
            ST_DATA: begin
                frame_bit  = data_q[6'(6'd63 - bit_cnt[5:0])];
                last_bit   = (bit_cnt == ({n_bytes, 3'b000} - 7'd1));
                next_field = ST_CRC;
            end
            ST_CRC: begin
                frame_bit  = crc_val[4'(4'd14 - bit_cnt[3:0])];
                last_bit   = (bit_cnt == 7'(CRC_W - 1));
                next_field = ST_CRC_DEL;
            end
            ST_CRC_DEL: begin
                last_bit   = 1'b1;
                next_field = ST_ACK;
            end
            ST_ACK: begin
                last_bit   = 1'b1;
                next_field = ST_EOF;
            end
            ST_EOF: begin
                // ACK delimiter followed by the seven EOF bits
                last_bit   = (bit_cnt == 7'(EOF_LEN));
                next_field = ST_IFS;
            end
            ST_IFS: begin
                last_bit   = (bit_cnt == 7'(IFS_LEN - 1));
                next_field = ST_IDLE;
            end
            default: begin
                frame_bit  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        run_cnt_n  = run_cnt;
        run_val_n  = run_val;
        tx_n       = tx_q;
        done_n     = 1'b0;
        id_n       = id_q;
        dlc_n      = dlc_q;
        data_n     = data_q;
        crc_en     = 1'b0;
        stuff_zone = (state == ST_ARB) || (state == ST_CTRL) ||
                     (state == ST_DATA) || (state == ST_CRC);
        // a run completed by CRC[0] is still stuffed on the first CRC_DEL tick
        stuff_now  = (stuff_zone || state == ST_CRC_DEL) &&
                     (run_cnt == RUN_W'(STUFF_LEN));

        if (state == ST_IDLE) begin
            if (start) begin
                id_n      = id;
                dlc_n     = dlc;
                data_n    = data;
                state_n   = ST_ARB;
                bit_cnt_n = '0;
                run_cnt_n = '0;
            end
        end else if (bit_tick) begin
            if (stuff_now) begin
                tx_n      = ~run_val;
                run_val_n = ~run_val;
                run_cnt_n = RUN_W'(1);
            end else begin
                tx_n   = frame_bit;
                crc_en = (state == ST_ARB) || (state == ST_CTRL) || (state == ST_DATA);
                if (stuff_zone) begin
                    run_val_n = frame_bit;
                    if (run_cnt != '0 && frame_bit == run_val)
                        run_cnt_n = run_cnt + 1'b1;
                    else
                        run_cnt_n = RUN_W'(1);
                end else begin
                    run_cnt_n = '0;
                end
                if (last_bit) begin
                    bit_cnt_n = '0;
                    state_n   = next_field;
                    done_n    = (state == ST_IFS);
                end else begin
                    bit_cnt_n = bit_cnt + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_tx_framer.sv
// Bench for can_tx_framer: a reference frame builder fills an expected bit
// queue, and every bit_tick pops one bit and compares it with tx.
module tb_can_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_tick;
    logic        start;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        tx;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [0:0]  exp_q[$];
    logic [0:0]  cap_q[$];
    int          exp_len;

    always #5 clk = ~clk;

    can_tx_framer #(.STUFF_LEN(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_tick (bit_tick),
        .start    (start),
        .id       (id),
        .dlc      (dlc),
        .data     (data),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    // Reference frame: fields, CRC-15 over SOF..data, stuffing, fixed tail
    task automatic build_expected(input logic [10:0] f_id, input logic [3:0] f_dlc,
                                  input logic [63:0] f_data);
        logic        ub[$];
        logic [14:0] crc;
        logic        nxt;
        logic        val;
        int          cnt;
        int          nb;
        ub.push_back(1'b0);
        for (int i = 10; i >= 0; i--) ub.push_back(f_id[i]);
        repeat (3) ub.push_back(1'b0);
        for (int i = 3; i >= 0; i--) ub.push_back(f_dlc[i]);
        nb = (f_dlc > 4'd8) ? 8 : int'(f_dlc);
        for (int i = 0; i < nb * 8; i++) ub.push_back(f_data[63 - i]);
        crc = '0;
        foreach (ub[i]) begin
            nxt = ub[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) ub.push_back(crc[i]);
        exp_q.delete();
        cnt = 0;
        val = 1'b0;
        foreach (ub[i]) begin
            if (cnt == 5) begin
                exp_q.push_back(~val);
                val = ~val;
                cnt = 1;
            end
            if (cnt != 0 && ub[i] == val) cnt++;
            else begin
                cnt = 1;
                val = ub[i];
            end
            exp_q.push_back(ub[i]);
        end
        if (cnt == 5) exp_q.push_back(~val);
        repeat (13) exp_q.push_back(1'b1);
        exp_len = exp_q.size();
    endtask

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_frame(input logic [10:0] f_id, input logic [3:0] f_dlc,
                             input logic [63:0] f_data, input int period,
                             input bit mid_start, input string name);
        int   cyc;
        int   ticks;
        bit   tick_v;
        bit   got_done;
        logic exp_bit;
        logic hold_bit;
        build_expected(f_id, f_dlc, f_data);
        cap_q.delete();
        id       = f_id;
        dlc      = f_dlc;
        data     = f_data;
        start    = 1'b1;
        bit_tick = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || tx !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: busy=%b tx=%b done=%b, required busy=1 tx=1 done=0",
                     name, busy, tx, done);
        end
        cyc      = 0;
        ticks    = 0;
        got_done = 0;
        hold_bit = 1'b1;
        while (!got_done && cyc < 4000) begin
            tick_v   = (cyc % period) == 0;
            bit_tick = tick_v;
            if (mid_start && ticks == 4 && tick_v) begin
                start = 1'b1;
                id    = ~f_id;
                dlc   = f_dlc + 4'd1;
                data  = ~f_data;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (tick_v) begin
                ticks++;
                cap_q.push_back(tx);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_bit: tick %0d tx=%b, required no further frame bits",
                             name, ticks, tx);
                end else begin
                    exp_bit = exp_q.pop_front();
                    if (tx !== exp_bit) begin
                        n_fail++;
                        $display("FAIL %s bit[%0d]: tx=%b, required %b", name, ticks - 1, tx, exp_bit);
                    end
                    hold_bit = exp_bit;
                end
                if (done !== 1'b1) begin
                    n_tests++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s busy_mid: tick %0d busy=%b, required 1", name, ticks, busy);
                    end
                end
            end else begin
                n_tests++;
                if (tx !== hold_bit) begin
                    n_fail++;
                    $display("FAIL %s tx_hold: cycle %0d tx=%b, required %b", name, cyc, tx, hold_bit);
                end
            end
            if (done === 1'b1) got_done = 1;
        end
        bit_tick = 1'b0;
        start    = 1'b0;
        n_tests++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done within %0d cycles, required done", name, cyc);
        end
        n_tests++;
        if (ticks != exp_len) begin
            n_fail++;
            $display("FAIL %s tick_count: %0d ticks to done, required %0d", name, ticks, exp_len);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic check_idle(input string name);
        n_tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     name, tx, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst      = 1'b0;
        bit_tick = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_idle("idle_with_ticks");
        end
        bit_tick = 1'b0;
    endtask

    task automatic test_zero_frame();
        int ones;
        run_frame(11'h000, 4'd0, 64'h0, 1, 0, "zero_frame");
        n_tests++;
        if (cap_q.size() != 53) begin
            n_fail++;
            $display("FAIL zero_len: %0d bit_ticks, required 53", cap_q.size());
        end
        ones = 0;
        for (int i = 0; i < 40 && i < cap_q.size(); i++) if (cap_q[i] == 1'b1) ones++;
        n_tests++;
        if (ones != 6) begin
            n_fail++;
            $display("FAIL zero_stuff_ones: %0d ones in first 40 bits, required 6", ones);
        end
    endtask

    task automatic test_ones_id();
        logic [13:0] pat;
        pat = 14'b01111101111101;
        run_frame(11'h7FF, 4'd0, 64'h0, 1, 0, "ones_id");
        for (int i = 0; i < 14; i++) begin
            n_tests++;
            if (i >= cap_q.size() || cap_q[i] !== pat[13 - i]) begin
                n_fail++;
                $display("FAIL ones_prefix[%0d]: got %b, required %b", i,
                         (i < cap_q.size()) ? cap_q[i] : 1'bx, pat[13 - i]);
            end
        end
    endtask

    task automatic test_dlc9();
        run_frame(11'h5A3, 4'd9, 64'h0123456789ABCDEF, 1, 0, "dlc9");
    endtask

    task automatic test_start_ignored();
        run_frame(11'h123, 4'd4, 64'hDEADBEEF_CAFEF00D, 1, 1, "start_ignored");
    endtask

    task automatic test_reset_mid_frame();
        id       = 11'h2AA;
        dlc      = 4'd8;
        data     = 64'hFFFF_0000_AAAA_5555;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        bit_tick = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_frame");
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check_idle("no_resume");
        end
        bit_tick = 1'b0;
        @(negedge clk);
        run_frame(11'h0F0, 4'd3, 64'h8001_7E00_0000_0000, 1, 0, "after_reset");
    endtask

    task automatic test_slow_tick();
        run_frame(11'h7FF, 4'd0, 64'h0, 7, 0, "slow_ones");
        run_frame(11'h31C, 4'd2, 64'hF0F0_0000_0000_0000, 7, 0, "slow_data");
    endtask

    task automatic test_back_to_back();
        run_frame(11'h001, 4'd1, 64'h8000_0000_0000_0000, 1, 0, "b2b_first");
        run_frame(11'h400, 4'd15, 64'h0000_0000_FFFF_FFFF, 1, 0, "b2b_second");
    endtask

    task automatic test_random();
        logic [10:0] r_id;
        logic [3:0]  r_dlc;
        logic [63:0] r_data;
        for (int k = 0; k < 4; k++) begin
            r_id   = 11'($urandom_range(0, 2047));
            r_dlc  = 4'($urandom_range(0, 15));
            r_data = {32'($urandom), 32'($urandom)};
            run_frame(r_id, r_dlc, r_data, int'($urandom_range(1, 3)), 0, "random");
        end
    endtask

    initial begin
        rst      = 1'b1;
        bit_tick = 1'b0;
        start    = 1'b0;
        id       = '0;
        dlc      = '0;
        data     = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_zero_frame();
        @(negedge clk);
        test_ones_id();
        @(negedge clk);
        test_dlc9();
        @(negedge clk);
        test_start_ignored();
        @(negedge clk);
        test_reset_mid_frame();
        @(negedge clk);
        test_slow_tick();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule
